sprite_motion_controller: RTL and testbench
===========================================

# sprite_motion_controller

Per-frame motion and display sequencer for the 11x48 player sprite bitmap. Holds the sprite's top-left position, updates it once per video frame from direction requests, clamps it to the screen, and reverts and blinks it after a collision. For every scanned pixel it generates the in-bracket flag and the X/Y offsets that index the sprite bitmap, registered so that they stay aligned with the pixel stream.

## Interface
Parameters:
- OBJECT_WIDTH_X, 11: sprite width in pixels.
- OBJECT_HEIGHT_Y, 48: sprite height in pixels.
- SCREEN_W, 640: visible width.
- SCREEN_H, 480: visible height.
- INIT_X, 320: top-left X after reset.
- INIT_Y, 400: top-left Y after reset.
- SPEED, 4: pixels moved per frame per axis.
- BLINK_FRAMES, 32: length of the post-collision blink, in frames.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at the start of each frame.
- pixelX  in  11  current scan X.
- pixelY  in  11  current scan Y.
- moveLeft, moveRight, moveUp, moveDown  in  1 each  level direction requests, sampled at startOfFrame.
- collision  in  1  sprite overlaps an obstacle on this cycle.
- InsideRectangle  out  1  registered: the pixel is inside the sprite bracket and is not blanked.
- offsetX  out  11  registered: pixelX − topLeftX, valid when InsideRectangle=1.
- offsetY  out  11  registered: pixelY − topLeftY, valid when InsideRectangle=1.
- topLeftX  out  11  current position X.
- topLeftY  out  11  current position Y.
- blinkActive  out  1  high while the FSM is in BLINK.

## Operation
- State registers:
  - topLeftX/Y: current position.
  - prevX/Y: position before the last update.
  - colLatch: sticky collision flag.
  - blinkCnt: 6-bit frame counter.
  - FSM state.
- colLatch is set by collision on any cycle, including a startOfFrame cycle. It clears on startOfFrame after being consumed.
- FSM states:
  - NORMAL:
    - On startOfFrame with colLatch=1: topLeft ← prev, blinkCnt ← 0, go to BLINK.
    - On startOfFrame with colLatch=0: prev ← topLeft, then apply the motion rule.
  - BLINK: motion rule and collision handling run exactly as in NORMAL.
    - On each startOfFrame, blinkCnt increments.
    - When blinkCnt reaches BLINK_FRAMES−1, go to NORMAL on that startOfFrame.
    - A collision during BLINK reverts the position and restarts blinkCnt at 0.
- Motion rule, applied per axis:
  - left XOR right (or up XOR down) moves by SPEED in that direction.
  - Both requests or neither: no change on that axis.
- Clamping:
  - X is clamped to [0, SCREEN_W−OBJECT_WIDTH_X]; Y to [0, SCREEN_H−OBJECT_HEIGHT_Y].
  - Subtraction is done in 12-bit signed arithmetic. A negative result saturates to 0; a result above the maximum saturates to the maximum.
- Bracket test:
  - inside = (pixelX ≥ topLeftX) and (pixelX < topLeftX+OBJECT_WIDTH_X) and the same test for Y.
  - Comparisons are 12-bit unsigned, so no wrap is possible.
- Blanking: while in BLINK with blinkCnt[2]=1, InsideRectangle is forced to 0. This gives a 4-frame on / 4-frame off pattern.
- Offsets: when not inside, offsetX/offsetY are driven to 0, so the bitmap ROM is never indexed out of range.

## Timing
- Reset values:
  - topLeftX=INIT_X, topLeftY=INIT_Y, prev equal to the same values.
  - colLatch=0, blinkCnt=0, state=NORMAL.
  - InsideRectangle=0, offsetX=0, offsetY=0, blinkActive=0.
- A reset asserted mid-frame or mid-blink returns all of the above immediately, without waiting for a clock edge.
- Position changes in the cycle after startOfFrame and is stable for the rest of the frame.
- InsideRectangle and the offsets have a latency of 1 cycle from pixelX/pixelY. The downstream bitmap adds 1 more cycle, so the color arrives 2 cycles after the coordinates.
- If collision and startOfFrame occur on the same cycle, the collision belongs to the ending frame: the revert happens on that same startOfFrame.
- blinkActive is registered with the state and changes the cycle after startOfFrame.

## Test plan
- Reset then one frame with no input: topLeft=(320,400); InsideRectangle=1 exactly for pixels X 320..330, Y 400..447, each asserted 1 cycle after its coordinate; offset at (325,410)=(5,10).
- moveLeft held for 81 frames from X=320: X steps 316, 312 … reaches 0 on frame 80 and stays 0 on frame 81.
- moveDown held from Y=400: Y saturates at 432 (480−48); moveUp and moveDown together cause no change.
- Collision pulse mid-frame after moving from X=320 to 324: at the next startOfFrame X=320 and blinkActive=1; InsideRectangle is suppressed in frames 4–7, 12–15, …; NORMAL is re-entered after 32 frames.
- Collision on the startOfFrame cycle itself: revert occurs on that startOfFrame. A second collision during BLINK frame 10 restarts blinkCnt at 0.
- Assert reset during BLINK frame 5: outputs return to the reset values asynchronously, and after release the position is (320,400) in NORMAL.

Source files
------------

// File: rtl/sprite_motion_controller.sv
// Per-frame position sequencer for the player sprite: moves, clamps, reverts and blinks on
// collision, and produces registered bracket/offset signals aligned with the pixel stream.
module sprite_motion_controller #(
   parameter int unsigned OBJECT_WIDTH_X = 11,
   parameter int unsigned OBJECT_HEIGHT_Y = 48,
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480,
   parameter int unsigned INIT_X = 320,
   parameter int unsigned INIT_Y = 400,
   parameter int unsigned SPEED = 4,
   parameter int unsigned BLINK_FRAMES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        startOfFrame,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   input  logic        moveLeft,
   input  logic        moveRight,
   input  logic        moveUp,
   input  logic        moveDown,
   input  logic        collision,
   output logic        InsideRectangle,
   output logic [10:0] offsetX,
   output logic [10:0] offsetY,
   output logic [10:0] topLeftX,
   output logic [10:0] topLeftY,
   output logic        blinkActive
);
   localparam int unsigned CW = 11;
   localparam int unsigned EW = 12;
   localparam int unsigned BW = 6;
   localparam logic [CW-1:0] X_MAX = CW'(SCREEN_W - OBJECT_WIDTH_X);
   localparam logic [CW-1:0] Y_MAX = CW'(SCREEN_H - OBJECT_HEIGHT_Y);
   localparam logic [CW-1:0] X_RST = CW'(INIT_X);
   localparam logic [CW-1:0] Y_RST = CW'(INIT_Y);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   typedef enum logic {NORMAL = 1'b0, BLINK = 1'b1} state_t;

   state_t        state, state_next;
   logic [CW-1:0] prev_x, prev_y;
   logic [CW-1:0] x_next, y_next, prev_x_next, prev_y_next;
   logic [BW-1:0] blink_cnt, cnt_next;
   logic          col_latch, col_latch_next, col_hit;
   logic [EW-1:0] px, py, lx, ly;
   logic          in_x, in_y, visible;

   // One axis of motion: saturating step in 12-bit signed arithmetic.
   function automatic logic [CW-1:0] step_axis(input logic [CW-1:0] pos, input logic dec,
                                               input logic inc, input logic [CW-1:0] max_pos);
      logic signed [EW-1:0] sum;
      logic [CW-1:0]        res;
      res = pos;
      if (dec && !inc) begin
         sum = $signed({1'b0, pos}) - $signed(EW'(SPEED));
         res = sum[EW-1] ? '0 : CW'(sum);
      end else if (inc && !dec) begin
         sum = $signed({1'b0, pos}) + $signed(EW'(SPEED));
         res = (sum > $signed({1'b0, max_pos})) ? max_pos : CW'(sum);
      end
      return res;
   endfunction

   // A collision on the startOfFrame cycle still belongs to the ending frame.
   assign col_hit = col_latch | collision;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= NORMAL;
         blinkActive <= 1'b0;
      end else begin
         state       <= state_next;
         blinkActive <= (state_next == BLINK);
      end
   end

   always_comb begin
      state_next = state;
      if (startOfFrame) begin
         if (col_hit)
            state_next = BLINK;
         else if (state == BLINK && blink_cnt == BLINK_LAST)
            state_next = NORMAL;
      end
   end

   always_comb begin
      x_next         = topLeftX;
      y_next         = topLeftY;
      prev_x_next    = prev_x;
      prev_y_next    = prev_y;
      cnt_next       = blink_cnt;
      col_latch_next = col_latch | collision;
      if (startOfFrame) begin
         col_latch_next = 1'b0;
         if (col_hit) begin
            x_next   = prev_x;
            y_next   = prev_y;
            cnt_next = '0;
         end else begin
            prev_x_next = topLeftX;
            prev_y_next = topLeftY;
            x_next      = step_axis(topLeftX, moveLeft, moveRight, X_MAX);
            y_next      = step_axis(topLeftY, moveUp, moveDown, Y_MAX);
            if (state == BLINK)
               cnt_next = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BW'(1);
         end
      end
   end

   // Bracket test in 12 bits so topLeft+width never wraps.
   assign px      = {1'b0, pixelX};
   assign py      = {1'b0, pixelY};
   assign lx      = {1'b0, topLeftX};
   assign ly      = {1'b0, topLeftY};
   assign in_x    = (px >= lx) && (px < lx + EW'(OBJECT_WIDTH_X));
   assign in_y    = (py >= ly) && (py < ly + EW'(OBJECT_HEIGHT_Y));
   assign visible = in_x && in_y && !(state == BLINK && blink_cnt[2]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         topLeftX        <= X_RST;
         topLeftY        <= Y_RST;
         prev_x          <= X_RST;
         prev_y          <= Y_RST;
         blink_cnt       <= '0;
         col_latch       <= 1'b0;
         InsideRectangle <= 1'b0;
         offsetX         <= '0;
         offsetY         <= '0;
      end else begin
         topLeftX        <= x_next;
         topLeftY        <= y_next;
         prev_x          <= prev_x_next;
         prev_y          <= prev_y_next;
         blink_cnt       <= cnt_next;
         col_latch       <= col_latch_next;
         InsideRectangle <= visible;
         offsetX         <= visible ? pixelX - topLeftX : '0;
         offsetY         <= visible ? pixelY - topLeftY : '0;
      end
   end
endmodule

// File: tb/tb_sprite_motion_controller.sv
// Directed bench for sprite_motion_controller: motion, clamping, bracket timing,
// collision revert/blink and asynchronous reset.
module tb_sprite_motion_controller;
   logic        clk, reset, startOfFrame;
   logic [10:0] pixelX, pixelY;
   logic        moveLeft, moveRight, moveUp, moveDown, collision;
   logic        InsideRectangle, blinkActive;
   logic [10:0] offsetX, offsetY, topLeftX, topLeftY;
   int          checks = 0;
   int          errors = 0;

   sprite_motion_controller dut (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
      .pixelX(pixelX), .pixelY(pixelY),
      .moveLeft(moveLeft), .moveRight(moveRight), .moveUp(moveUp), .moveDown(moveDown),
      .collision(collision), .InsideRectangle(InsideRectangle),
      .offsetX(offsetX), .offsetY(offsetY), .topLeftX(topLeftX), .topLeftY(topLeftY),
      .blinkActive(blinkActive)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One startOfFrame pulse carrying the given requests; returns at the following negedge.
   task automatic frame(input logic l, input logic r, input logic u, input logic d, input logic col);
      moveLeft = l; moveRight = r; moveUp = u; moveDown = d; collision = col;
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      moveLeft = 1'b0; moveRight = 1'b0; moveUp = 1'b0; moveDown = 1'b0; collision = 1'b0;
   endtask

   task automatic pix(input string tag, input int x, input int y, input logic ein,
                      input int eox, input int eoy);
      pixelX = 11'(x);
      pixelY = 11'(y);
      @(negedge clk);
      chk({tag, ".in"}, 32'(InsideRectangle), 32'(ein));
      chk({tag, ".ox"}, 32'(offsetX), 32'(eox));
      chk({tag, ".oy"}, 32'(offsetY), 32'(eoy));
   endtask

   initial begin
      reset = 1'b1; startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
      moveLeft = 1'b0; moveRight = 1'b0; moveUp = 1'b0; moveDown = 1'b0; collision = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.x", 32'(topLeftX), 320);
      chk("rst.y", 32'(topLeftY), 400);
      chk("rst.in", 32'(InsideRectangle), 0);
      chk("rst.ox", 32'(offsetX), 0);
      chk("rst.oy", 32'(offsetY), 0);
      chk("rst.blink", 32'(blinkActive), 0);
      reset = 1'b0;
      @(negedge clk);

      // Idle frame, bracket edges and one-cycle latency
      frame(0, 0, 0, 0, 0);
      chk("f1.x", 32'(topLeftX), 320);
      chk("f1.y", 32'(topLeftY), 400);
      pix("p319", 319, 400, 0, 0, 0);
      pixelX = 11'd320; pixelY = 11'd400;
      #1 chk("lat.pre", 32'(InsideRectangle), 0);
      @(negedge clk);
      chk("lat.in", 32'(InsideRectangle), 1);
      pix("p325", 325, 410, 1, 5, 10);
      pix("p330", 330, 447, 1, 10, 47);
      pix("p331", 331, 447, 0, 0, 0);
      pix("p448", 330, 448, 0, 0, 0);
      pix("p399", 320, 399, 0, 0, 0);

      // Left clamp at 0
      for (int i = 1; i <= 81; i++) begin
         frame(1, 0, 0, 0, 0);
         chk("left.x", 32'(topLeftX), (320 > 4 * i) ? 320 - 4 * i : 0);
      end

      // Down clamp at 432, opposing requests cancel
      for (int i = 1; i <= 10; i++) begin
         frame(0, 0, 0, 1, 0);
         chk("down.y", 32'(topLeftY), (400 + 4 * i > 432) ? 432 : 400 + 4 * i);
      end
      frame(0, 0, 1, 1, 0);
      chk("ud.y", 32'(topLeftY), 432);
      frame(1, 1, 0, 0, 0);
      chk("lr.x", 32'(topLeftX), 0);
      frame(0, 0, 1, 0, 0);
      chk("up.y", 32'(topLeftY), 428);
      frame(0, 1, 0, 0, 0);
      chk("right.x", 32'(topLeftX), 4);

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst2.x", 32'(topLeftX), 320);

      // Mid-frame collision then full blink sequence
      frame(0, 1, 0, 0, 0);
      chk("mv.x", 32'(topLeftX), 324);
      repeat (3) @(negedge clk);
      collision = 1'b1;
      @(negedge clk);
      collision = 1'b0;
      @(negedge clk);
      chk("col.hold.x", 32'(topLeftX), 324);
      chk("col.hold.blink", 32'(blinkActive), 0);
      frame(0, 0, 0, 0, 0);
      chk("rev.x", 32'(topLeftX), 320);
      chk("rev.blink", 32'(blinkActive), 1);
      for (int k = 0; k < 32; k++) begin
         if ((k & 4) == 0) pix("blk.on", 325, 410, 1, 5, 10);
         else              pix("blk.off", 325, 410, 0, 0, 0);
         chk("blk.active", 32'(blinkActive), 1);
         frame(0, 0, 0, 0, 0);
      end
      chk("blk.end", 32'(blinkActive), 0);
      pix("norm", 325, 410, 1, 5, 10);
      chk("norm.x", 32'(topLeftX), 320);

      // Collision on startOfFrame; second collision restarts the blink count
      frame(0, 1, 0, 0, 0);
      chk("mv2.x", 32'(topLeftX), 324);
      frame(0, 0, 0, 0, 1);
      chk("sof.x", 32'(topLeftX), 320);
      chk("sof.blink", 32'(blinkActive), 1);
      repeat (9) frame(0, 0, 0, 0, 0);
      frame(0, 1, 0, 0, 0);
      chk("b10.x", 32'(topLeftX), 324);
      @(negedge clk);
      collision = 1'b1;
      @(negedge clk);
      collision = 1'b0;
      frame(0, 0, 0, 0, 0);
      chk("b10.rev.x", 32'(topLeftX), 320);
      chk("b10.blink", 32'(blinkActive), 1);
      repeat (3) frame(0, 0, 0, 0, 0);
      pix("rs3", 325, 410, 1, 5, 10);
      frame(0, 0, 0, 0, 0);
      pix("rs4", 325, 410, 0, 0, 0);
      frame(0, 0, 0, 1, 0);
      chk("b5.y", 32'(topLeftY), 404);

      // Asynchronous reset in blink frame 5, between clock edges
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst.x", 32'(topLeftX), 320);
      chk("arst.y", 32'(topLeftY), 400);
      chk("arst.blink", 32'(blinkActive), 0);
      chk("arst.in", 32'(InsideRectangle), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post.y", 32'(topLeftY), 400);
      frame(0, 0, 0, 0, 0);
      chk("post.blink", 32'(blinkActive), 0);
      chk("post.x", 32'(topLeftX), 320);
      pix("post", 325, 410, 1, 5, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
